mem_access_ctrl: RTL

Multi-cycle data-memory access controller for the MEM stage of the MIPS pipeline. It accepts one load/store per instruction, drives a req/ack data-memory port with a word-aligned address, byte enables and lane-replicated store data, and stalls the pipeline until the access completes. It returns lane-aligned, sign- or zero-extended load data to the write-back path.

---
 rtl/mem_access_ctrl_pkg.sv | 40 ++++
 rtl/mem_access_ctrl_treatload.sv | 25 ++
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared header for the MEM-stage access controller: data width, MIPS load/store
// opcodes, FSM state encoding and small opcode-classification helpers.
package mem_access_ctrl_pkg;

  localparam int DWIDTH       = 32;
  localparam int OPCODE_WIDTH = 6;

  localparam logic [OPCODE_WIDTH-1:0] OP_LB  = 6'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_LH  = 6'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_LBU = 6'h24;
  localparam logic [OPCODE_WIDTH-1:0] OP_LHU = 6'h25;
  localparam logic [OPCODE_WIDTH-1:0] OP_SB  = 6'h28;
  localparam logic [OPCODE_WIDTH-1:0] OP_SH  = 6'h29;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_load(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_treatload.sv
// Load extension: takes the lane-shifted read word and sign/zero-extends it
// according to the load opcode. Anything that is not a load yields 0.
module mem_access_ctrl_treatload
  import mem_access_ctrl_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DWIDTH-1:0]       word,
  output logic [DWIDTH-1:0]       result
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    result = '0;
    unique case (opcode)
      OP_LB:   result = {{24{word[7]}}, word[7:0]};
      OP_LBU:  result = {24'd0, word[7:0]};
      OP_LH:   result = {{16{word[15]}}, word[15:0]};
      OP_LHU:  result = {16'd0, word[15:0]};
      OP_LW:   result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one req/ack access per load/store,
// pipeline stall while in flight. Optional macro MISALIGN_TRAP_EN enables the
// misalignment trap; without it misaligned half/word addresses are force-aligned.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic                    mac_i_clk,
  input  logic                    mac_i_rst,
  input  logic                    mac_i_req,
  input  logic [OPCODE_WIDTH-1:0] mac_i_opcode,
  input  logic [AWIDTH-1:0]       mac_i_addr,
  input  logic [DWIDTH-1:0]       mac_i_wdata,
  output logic                    mac_o_stall,
  output logic [DWIDTH-1:0]       mac_o_rdata,
  output logic                    mac_o_rvalid,
  output logic                    mac_o_misalign,
  output logic                    mac_o_mem_req,
  output logic                    mac_o_mem_we,
  output logic [AWIDTH-1:0]       mac_o_mem_addr,
  output logic [DWIDTH-1:0]       mac_o_mem_wdata,
  output logic [3:0]              mac_o_mem_be,
  input  logic                    mac_i_mem_ack,
  input  logic [DWIDTH-1:0]       mac_i_mem_rdata
);

  state_t                  state_q, state_d;
  logic                    mem_op, misaligned, latch;
  logic [1:0]              lane_n, lane_q;
  logic [3:0]              be_n;
  logic [DWIDTH-1:0]       wdata_n, shifted, load_ext, rdata_q;
  logic [OPCODE_WIDTH-1:0] op_q;

  assign mem_op = is_load(mac_i_opcode) || is_store(mac_i_opcode);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (is_half(mac_i_opcode) && mac_i_addr[0]) ||
                      (is_word(mac_i_opcode) && (mac_i_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // State register; reset abandons any in-flight access.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge mac_i_clk or posedge mac_i_rst) begin
    if (mac_i_rst) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mac_o_stall = 1'b0;
    latch       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mac_i_req && mem_op) begin
          mac_o_stall = 1'b1;
          latch       = 1'b1;
          state_d     = misaligned ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        mac_o_stall = 1'b1;
        if (mac_i_mem_ack) state_d = ST_DONE;
      end
      // The same instruction is still in MEM here, so its req is not re-taken.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane selection with forced alignment, byte enables and store replication.
  always_comb begin
    lane_n  = mac_i_addr[1:0];
    be_n    = 4'hF;
    wdata_n = '0;
    if (is_half(mac_i_opcode)) lane_n[0] = 1'b0;
    if (is_word(mac_i_opcode)) lane_n    = 2'b00;
    unique case (mac_i_opcode)
      OP_SB: begin
        wdata_n = {4{mac_i_wdata[7:0]}};
        be_n    = 4'b0001 << lane_n;
      end
      OP_SH: begin
        wdata_n = {2{mac_i_wdata[15:0]}};
        be_n    = 4'b0011 << {lane_n[1], 1'b0};
      end
      OP_SW:   wdata_n = mac_i_wdata;
      default: wdata_n = '0;
    endcase
  end

  assign shifted = mac_i_mem_rdata >> {lane_q, 3'b000};

  mem_access_ctrl_treatload u_treatload (
    .opcode (op_q),
    .word   (shifted),
    .result (load_ext)
  );

  always_ff @(posedge mac_i_clk or posedge mac_i_rst) begin
    if (mac_i_rst) begin
      op_q            <= '0;
      lane_q          <= '0;
      mac_o_mem_we    <= 1'b0;
      mac_o_mem_addr  <= '0;
      mac_o_mem_wdata <= '0;
      mac_o_mem_be    <= '0;
      rdata_q         <= '0;
    end else begin
      if (latch) begin
        op_q            <= mac_i_opcode;
        lane_q          <= lane_n;
        mac_o_mem_we    <= is_store(mac_i_opcode);
        mac_o_mem_addr  <= {mac_i_addr[AWIDTH-1:2], 2'b00};
        mac_o_mem_wdata <= wdata_n;
        mac_o_mem_be    <= be_n;
        if (misaligned) rdata_q <= '0;
      end
      if (state_q == ST_BUSY && mac_i_mem_ack)
        rdata_q <= mac_o_mem_we ? '0 : load_ext;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge mac_i_clk or posedge mac_i_rst) begin
    if (mac_i_rst)  misalign_q <= 1'b0;
    else if (latch) misalign_q <= misaligned;
  end

  assign mac_o_misalign = (state_q == ST_DONE) && misalign_q;
`else
  assign mac_o_misalign = 1'b0;
`endif

  assign mac_o_mem_req = (state_q == ST_BUSY);
  assign mac_o_rvalid  = (state_q == ST_DONE);
  assign mac_o_rdata   = rdata_q;

endmodule
